// File: rtl/cla_mw_add_seq.sv
// Multi-word adder: one 5-bit carry-lookahead slice reused over WORDS cycles, LSB limb first.
// Optional macro CLA_MW_ADD_SEQ_SUB_EN adds op_sub (A - B via ~B and carry-in 1).
module cla_mw_add_seq #(
  parameter int WORDS = 4,
  localparam int W = 5 * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
`ifdef CLA_MW_ADD_SEQ_SUB_EN
  input  logic         op_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_out,
  output logic         cout_out,
  output logic         ovf_out,
  output logic         busy,
  output logic [2:0]   limb_idx
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and the payload stays stable while valid is high.

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  state_t       state;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic         carry;

  logic [4:0] a_l, b_l, g, p, s;
  logic [5:0] c;

  // Lookahead slice: every carry computed directly from generate/propagate terms.
  always_comb begin
    a_l  = a_reg[5*limb_idx +: 5];
    b_l  = b_reg[5*limb_idx +: 5];
    g    = a_l & b_l;
    p    = a_l ^ b_l;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
      ovf_out   <= 1'b0;
      busy      <= 1'b0;
      limb_idx  <= 3'd0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a_in;
`ifdef CLA_MW_ADD_SEQ_SUB_EN
            b_reg    <= op_sub ? ~b_in : b_in;
            carry    <= op_sub ? 1'b1 : cin;
`else
            b_reg    <= b_in;
            carry    <= cin;
`endif
            limb_idx <= 3'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_out[5*limb_idx +: 5] <= s;
          carry <= c[5];
          if (limb_idx == LAST_IDX) begin
            cout_out  <= c[5];
            ovf_out   <= c[4] ^ c[5];
            limb_idx  <= 3'd0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            limb_idx <= limb_idx + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_mw_add_seq.sv
// Self-checking bench for cla_mw_add_seq: directed corner cases plus random operands
// checked against an integer-arithmetic reference model through an expected queue.
module tb_cla_mw_add_seq;

  localparam int WORDS = 4;
  localparam int W = 5 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
`ifdef CLA_MW_ADD_SEQ_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ovf_out;
  logic         busy;
  logic [2:0]   limb_idx;

  int n_checks = 0;
  int n_pass = 0;

  logic [W+1:0] exp_q[$];

  cla_mw_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef CLA_MW_ADD_SEQ_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out),
    .busy(busy), .limb_idx(limb_idx)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain unsigned/signed integer arithmetic, packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sub);
    longint md = longint'(1) << W;
    longint half = longint'(1) << (W - 1);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= half) ? ua - md : ua;
    longint sb = (ub >= half) ? ub - md : ub;
    longint tot, st;
    logic co, ov;
    if (sub) begin
      tot = ua - ub;
      co  = (ua >= ub);
      st  = sa - sb;
      if (tot < 0) tot = tot + md;
    end else begin
      tot = ua + ub + longint'(c);
      co  = (tot >= md);
      st  = sa + sb + longint'(c);
      if (tot >= md) tot = tot - md;
    end
    ov = (st >= half) || (st < -half);
    return {ov, co, W'(tot)};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_sum"}, sum_out, 0);
    check({tag, "_cout"}, cout_out, 0);
    check({tag, "_ovf"}, ovf_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_limb_idx"}, limb_idx, 0);
  endtask

  // Driver: starts and ends just after a falling edge; stall = cycles of out_ready low in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, input int stall);
    int cycles;
    logic [W+1:0] exp;
    check("in_ready_idle", in_ready, 1);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    out_ready = (stall == 0);
`ifdef CLA_MW_ADD_SEQ_SUB_EN
    op_sub = sub;
`endif
    exp_q.push_back(model(a, b, c, sub));
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < WORDS + 4) begin
      check("busy_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      check("limb_idx_run", limb_idx, cycles);
      if (stall > 0) begin
        in_valid = 1'b1;
        a_in = W'($urandom);
        b_in = W'($urandom);
        cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cycles++;
    end
    check("latency", cycles, WORDS);
    exp = exp_q.pop_front();
    if (!out_valid) return;
    check("limb_idx_done", limb_idx, 0);
    check("busy_done", busy, 1);
    check("result", {ovf_out, cout_out, sum_out}, exp);
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", {ovf_out, cout_out, sum_out}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("busy_idle", busy, 0);
    check("result_kept", {ovf_out, cout_out, sum_out}, exp);
  endtask

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    logic rs;
    // reset
    repeat (2) @(negedge clk);
    check_reset_vals("rst_low");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_idle");

    run_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 0);
    check("ripple_sum", sum_out, 20'h00000);
    check("ripple_cout", cout_out, 1);
    run_op(20'h12345, 20'h0ABCD, 1'b1, 1'b0, 0);
    check("mixed_sum", sum_out, 20'h1CF13);
    run_op(20'h7FFFF, 20'h00001, 1'b0, 1'b0, 5);
    check("ovf_sum", sum_out, 20'h80000);
    check("ovf_flag", ovf_out, 1);

    // abort mid-operation at limb 2
    a_in = 20'hFFFFF; b_in = 20'hFFFFF; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (limb_idx != 3'd2 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("reach_idx2", limb_idx, 2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WORDS + 2) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end
    run_op(20'h00003, 20'h00004, 1'b0, 1'b0, 0);
    check("post_abort_sum", sum_out, 20'h00007);

`ifdef CLA_MW_ADD_SEQ_SUB_EN
    run_op(20'h00005, 20'h00007, 1'b1, 1'b1, 0);
    check("sub_sum", sum_out, 20'hFFFFE);
    check("sub_cout", cout_out, 0);
    check("sub_ovf", ovf_out, 0);
    run_op(20'h80000, 20'h00001, 1'b0, 1'b1, 2);
    check("sub_ovf_sum", sum_out, 20'h7FFFF);
    check("sub_ovf_cout", cout_out, 1);
    check("sub_ovf_flag", ovf_out, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) ra = '1;
      rs = 1'b0;
`ifdef CLA_MW_ADD_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      run_op(ra, rb, 1'($urandom_range(0, 1)), rs, $urandom_range(0, 3));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
